// File: rtl/enemy_wave_engine.sv
// Falling-enemy engine: owns NUM_ENEMIES sprites (position, colour, fall timing) and
// drives the shared erase/redraw plot port, with LFSR respawn, hit latches and escape pulses.
module enemy_wave_engine #(
  parameter int unsigned NUM_ENEMIES = 2,
  parameter int unsigned SPRITE_W    = 4,
  parameter int unsigned SPRITE_H    = 4,
  parameter int unsigned DELAY       = 4500000,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_ENEMIES-1:0]     hit,
  output logic [7:0]                 x,
  output logic [6:0]                 y,
  output logic [2:0]                 colour,
  output logic                       plot,
  output logic                       busy,
  output logic [NUM_ENEMIES-1:0]     escaped,
  output logic [8*NUM_ENEMIES-1:0]   enemy_x,
  output logic [7*NUM_ENEMIES-1:0]   enemy_y
);
  localparam int unsigned Pixels = SPRITE_W * SPRITE_H;
  localparam int unsigned PixW   = (Pixels > 1) ? $clog2(Pixels) : 1;
  localparam int unsigned ChW    = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int unsigned CntW   = $clog2(DELAY);
  localparam logic [7:0]      MaxX    = 8'(SCREEN_W - SPRITE_W);
  localparam logic [6:0]      Bottom  = 7'(SCREEN_H - SPRITE_H);
  localparam logic [PixW-1:0] PixLast = PixW'(Pixels - 1);
  localparam logic [ChW-1:0]  ChLast  = ChW'(NUM_ENEMIES - 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(DELAY - 1);

  typedef enum logic [2:0] {StIdle, StErase, StUpdate, StDraw, StNext} state_e;

  function automatic logic [7:0] spawn_x(input logic [7:0] l);
    return (l <= MaxX) ? l : l - 8'd128;
  endfunction

  // An enemy is never drawn black, which would be indistinguishable from an erase.
  function automatic logic [2:0] colour_of(input logic [7:0] v);
    logic [2:0] c;
    c = {v[5:4], v[7] ^ v[6]};
    return (c == 3'b000) ? 3'b100 : c;
  endfunction

  state_e                 state_q, state_d;
  logic [ChW-1:0]         ch_q, ch_d;
  logic [PixW-1:0]        p_q, p_d;
  logic [CntW-1:0]        cnt_q;
  logic [7:0]             lfsr_q;
  logic                   pend_q, pend_d;
  logic [NUM_ENEMIES-1:0] hitp_q, hitp_d;
  logic [7:0]             ex_q [NUM_ENEMIES];
  logic [7:0]             ex_d [NUM_ENEMIES];
  logic [6:0]             ey_q [NUM_ENEMIES];
  logic [6:0]             ey_d [NUM_ENEMIES];
  logic [2:0]             ec_q [NUM_ENEMIES];
  logic [2:0]             ec_d [NUM_ENEMIES];
  logic [7:0]             x_d, spawn;
  logic [6:0]             y_d;
  logic [2:0]             colour_d;
  logic                   plot_d, busy_d, tick;
  logic [NUM_ENEMIES-1:0] esc_d;

  always_comb begin
    spawn   = spawn_x(lfsr_q);
    tick    = (cnt_q == '0);
    state_d = state_q;
    ch_d    = ch_q;
    p_d     = p_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    ec_d    = ec_q;
    pend_d  = pend_q | (tick & enable);
    hitp_d  = hitp_q | hit;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          ch_d    = '0;
          p_d     = '0;
          state_d = StErase;
        end
      end
      StErase, StDraw: begin
        if (p_q == PixLast) begin
          p_d     = '0;
          state_d = (state_q == StErase) ? StUpdate : StNext;
        end else begin
          p_d = p_q + 1'b1;
        end
      end
      StUpdate: begin
        state_d = StDraw;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
          if (ch_q == ChW'(i)) begin
            if (hitp_q[i] || ey_q[i] == Bottom) begin
              ex_d[i] = spawn;
              ey_d[i] = '0;
              ec_d[i] = colour_of(spawn);
            end else begin
              ey_d[i] = ey_q[i] + 7'd1;
            end
            // A hit arriving in this same cycle keeps the latch set for next frame.
            if (hitp_q[i]) hitp_d[i] = hit[i];
          end
        end
      end
      StNext: begin
        if (ch_q == ChLast) begin
          state_d = StIdle;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = StErase;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are precomputed from next state so they appear registered in the right cycle.
    plot_d   = (state_d == StErase) || (state_d == StDraw);
    busy_d   = (state_d != StIdle);
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    esc_d    = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (ch_d == ChW'(i)) begin
        if (plot_d) begin
          x_d = ex_d[i] + 8'(32'(p_d) % SPRITE_W);
          y_d = ey_d[i] + 7'(32'(p_d) / SPRITE_W);
        end
        if (state_d == StDraw) colour_d = ec_d[i];
        esc_d[i] = (state_d == StUpdate) && !hitp_d[i] && (ey_q[i] == Bottom);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
      p_q     <= '0;
      cnt_q   <= CntLoad;
      lfsr_q  <= 8'hA5;
      pend_q  <= 1'b0;
      hitp_q  <= '0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        ex_q[i] <= 8'(32 + 64 * i);
        ey_q[i] <= '0;
        ec_q[i] <= colour_of(8'(32 + 64 * i));
      end
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      escaped <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      p_q     <= p_d;
      cnt_q   <= tick ? CntLoad : cnt_q - 1'b1;
      lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      pend_q  <= pend_d;
      hitp_q  <= hitp_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      ec_q    <= ec_d;
      x       <= x_d;
      y       <= y_d;
      colour  <= colour_d;
      plot    <= plot_d;
      busy    <= busy_d;
      escaped <= esc_d;
    end
  end

  always_comb begin
    enemy_x = '0;
    enemy_y = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      enemy_x[8*i +: 8] = ex_q[i];
      enemy_y[7*i +: 7] = ey_q[i];
    end
  end

endmodule

// File: tb/tb_enemy_wave_engine.sv
// Scoreboard bench for enemy_wave_engine: a frame-schedule reference model queues the
// expected pixels and a negedge monitor compares plot traffic and per-cycle status.
module tb_enemy_wave_engine;
  localparam int unsigned N = 2, W = 4, H = 4, DLY = 50, SW = 160, SH = 120;
  localparam int unsigned WH = W * H, SLOT = 2 * WH + 2, FRAME = N * SLOT;
  localparam logic [6:0] BOT = 7'(SH - H);

  logic           clock = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [N-1:0]   hit = '0;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot, busy;
  logic [N-1:0]   escaped;
  logic [8*N-1:0] enemy_x;
  logic [7*N-1:0] enemy_y;

  enemy_wave_engine #(
    .NUM_ENEMIES(N), .SPRITE_W(W), .SPRITE_H(H), .DELAY(DLY), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .hit(hit), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .escaped(escaped), .enemy_x(enemy_x), .enemy_y(enemy_y)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  pix_t pq[$];

  int n_checks = 0, n_fail = 0, n_esc_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] next_lfsr(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] f_spawn(input logic [7:0] l);
    return (int'(l) <= SW - W) ? l : 8'(int'(l) - 128);
  endfunction

  function automatic logic [2:0] f_colour(input logic [7:0] v);
    logic [2:0] c;
    c = {v[5:4], v[7] ^ v[6]};
    return (c == 3'b000) ? 3'b100 : c;
  endfunction

  task automatic push_sprite(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] bc);
    pix_t e;
    for (int r = 0; r < H; r++)
      for (int col = 0; col < W; col++) begin
        e.x = bx + 8'(col);
        e.y = by + 7'(r);
        e.c = bc;
        pq.push_back(e);
      end
  endtask

  // Reference model: frames are scheduled arithmetically from their start cycle.
  int         c, off, chn, r;
  bit         started = 0, m_after_reset = 0, m_pend, m_active, busy_now;
  int         m_fstart;
  logic [7:0] m_lfsr, nx;
  logic [7:0] m_ex [N];
  logic [6:0] m_ey [N];
  logic [2:0] m_col [N];
  logic [N-1:0] m_hitp, exp_esc;
  bit         exp_busy, exp_plot, exp_upd0;

  always @(posedge clock) begin
    if (reset) begin
      c = 0; m_lfsr = 8'hA5; m_pend = 0; m_active = 0; m_fstart = 0; m_hitp = '0;
      for (int i = 0; i < N; i++) begin
        m_ex[i] = 8'(32 + 64 * i);
        m_ey[i] = '0;
        m_col[i] = f_colour(m_ex[i]);
      end
      pq.delete();
      exp_busy = 0; exp_plot = 0; exp_esc = '0; exp_upd0 = 0;
      m_after_reset = 1; started = 1;
    end else begin
      m_after_reset = 0;
      busy_now = m_active && c >= m_fstart && c < m_fstart + FRAME;
      if (busy_now) begin
        off = c - m_fstart; chn = off / SLOT; r = off % SLOT;
        if (r == WH) begin
          if (m_hitp[chn] || m_ey[chn] == BOT) begin
            nx = f_spawn(m_lfsr);
            m_ex[chn] = nx; m_ey[chn] = '0; m_col[chn] = f_colour(nx); m_hitp[chn] = 1'b0;
          end else begin
            m_ey[chn] = m_ey[chn] + 7'd1;
          end
          push_sprite(m_ex[chn], m_ey[chn], m_col[chn]);
          if (chn < N - 1) push_sprite(m_ex[chn+1], m_ey[chn+1], 3'b000);
        end
      end
      m_hitp = m_hitp | hit;
      if (!busy_now && m_pend) begin
        m_pend = 0; m_active = 1; m_fstart = c + 1;
        push_sprite(m_ex[0], m_ey[0], 3'b000);
      end else if ((c % DLY) == DLY - 1 && enable) begin
        m_pend = 1;
      end
      m_lfsr = next_lfsr(m_lfsr);
      c++;
      exp_busy = m_active && c >= m_fstart && c < m_fstart + FRAME;
      exp_plot = 0; exp_esc = '0; exp_upd0 = 0;
      if (exp_busy) begin
        off = c - m_fstart; chn = off / SLOT; r = off % SLOT;
        exp_plot = (r != WH) && (r <= 2 * WH);
        if (r == WH) begin
          exp_upd0 = (chn == 0);
          if (!m_hitp[chn] && m_ey[chn] == BOT) exp_esc[chn] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      logic [8*N-1:0] ex_pack;
      logic [7*N-1:0] ey_pack;
      pix_t p;
      for (int i = 0; i < N; i++) begin
        ex_pack[8*i +: 8] = m_ex[i];
        ey_pack[7*i +: 7] = m_ey[i];
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("plot", 32'(plot), 32'(exp_plot));
      chk("escaped", 32'(escaped), 32'(exp_esc));
      chk("enemy_x", 32'(enemy_x), 32'(ex_pack));
      chk("enemy_y", 32'(enemy_y), 32'(ey_pack));
      if (escaped != '0) n_esc_seen++;
      if (m_after_reset) begin
        chk("reset_x", 32'(x), 32'd0);
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_colour", 32'(colour), 32'd0);
      end
      if (plot === 1'b1) begin
        if (pq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pixel_unexpected: got (%0d,%0d,%0d) expected none", x, y, colour);
        end else begin
          p = pq.pop_front();
          chk("pix_x", 32'(x), 32'(p.x));
          chk("pix_y", 32'(y), 32'(p.y));
          chk("pix_colour", 32'(colour), 32'(p.c));
        end
      end
    end
  end

  task automatic wait_upd0_and_hit();
    int k;
    k = 0;
    while (!exp_upd0 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (!exp_upd0) begin
      n_checks++; n_fail++;
      $display("FAIL upd0_timeout: got no update window expected one within 2000 cycles");
    end else begin
      hit[0] = 1'b1;
      @(negedge clock);
      hit = '0;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; hit = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Undisturbed fall long enough for both enemies to escape.
    repeat (9000) @(negedge clock);

    // Hits landing exactly in enemy 0's update cycle.
    for (int k = 0; k < 5; k++) wait_upd0_and_hit();

    // Random hits with enable windows.
    for (int k = 0; k < 15000; k++) begin
      @(negedge clock);
      hit = ($urandom_range(0, 39) == 0) ? N'($urandom_range(1, 3)) : '0;
      if (k % 500 == 0) enable = ($urandom_range(0, 3) != 0);
    end
    hit = '0; enable = 1'b1;

    // Resets at random points, often mid-frame.
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(20, 300)) begin
        @(negedge clock);
        hit = ($urandom_range(0, 29) == 0) ? N'($urandom_range(1, 3)) : '0;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; hit = '0;
    end

    // Ticks with enable low must not start frames.
    enable = 1'b0;
    repeat (400) @(negedge clock);
    chk("queue_drained", 32'(pq.size()), 32'd0);
    chk("saw_escape", 32'(n_esc_seen > 0), 32'd1);
    for (int i = 0; i < N; i++) chk("x_in_range", 32'(int'(enemy_x[8*i +: 8]) <= SW - W), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
